// File: rtl/midi_tx_pkg.sv
// Shared MIDI constants, FSM state types and the status-byte helper for the transmit path.
package midi_tx_pkg;

  localparam int MIDI_PAYLOAD_BITS = 8;
  localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    M_IDLE,
    M_BYTE0,
    M_BYTE1,
    M_BYTE2
  } msgState_t;

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } byteState_t;

  // Note Off takes priority so a simultaneous request can never leave a note hanging.
  function automatic logic [MIDI_PAYLOAD_BITS-1:0] statusByte(input logic isOff,
                                                              input logic [3:0] channel);
    return {(isOff ? MIDI_NOTE_OFF : MIDI_NOTE_ON), channel};
  endfunction

endpackage

// File: rtl/midi_tx_uart_tx_byte.sv
// UART 8N1 byte serializer. A load arriving on the last cycle of the stop bit
// chains straight into the next start bit so consecutive frames have no gap.
module uart_tx_byte
  import midi_tx_pkg::*;
#(
  parameter int DIV = 320
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [MIDI_PAYLOAD_BITS-1:0] data_i,
  input  logic                         load_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         txData_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  byteState_t                   state;
  logic [CNT_W-1:0]             baudCnt;
  logic [2:0]                   bitIdx;
  logic [MIDI_PAYLOAD_BITS-1:0] shiftReg;
  logic                         txReg;
  logic                         bitEnd;

  assign bitEnd   = (baudCnt == CNT_LAST);
  // Combinational so the message FSM can load the next byte on the same edge.
  assign done_o   = (state == B_STOP) && bitEnd;
  assign busy_o   = (state != B_IDLE);
  assign txData_o = txReg;

  // Byte FSM, baud counter and LSB-first shifter; the line is registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= B_IDLE;
      baudCnt  <= '0;
      bitIdx   <= 3'd0;
      shiftReg <= '0;
      txReg    <= 1'b1;
    end else begin
      baudCnt <= (state == B_IDLE || bitEnd) ? '0 : baudCnt + 1'b1;
      unique case (state)
        B_IDLE: begin
          if (load_i) begin
            state    <= B_START;
            shiftReg <= data_i;
            txReg    <= 1'b0;
          end
        end
        B_START: begin
          if (bitEnd) begin
            state    <= B_DATA;
            bitIdx   <= 3'd0;
            txReg    <= shiftReg[0];
            shiftReg <= shiftReg >> 1;
          end
        end
        B_DATA: begin
          if (bitEnd) begin
            if (bitIdx == 3'd7) begin
              state <= B_STOP;
              txReg <= 1'b1;
            end else begin
              bitIdx   <= bitIdx + 3'd1;
              txReg    <= shiftReg[0];
              shiftReg <= shiftReg >> 1;
            end
          end
        end
        B_STOP: begin
          if (bitEnd) begin
            if (load_i) begin
              state    <= B_START;
              shiftReg <= data_i;
              txReg    <= 1'b0;
            end else begin
              state <= B_IDLE;
            end
          end
        end
        default: state <= B_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/midi_tx.sv
// MIDI Note On/Off transmitter: builds status/note/velocity and sends the three
// bytes as back-to-back 8N1 frames. A strobe on the final stop-bit edge starts the
// next message immediately, so ready_o stays low in that case.
module midi_tx
  import midi_tx_pkg::*;
#(
  parameter int CLK_FREQ     = 10_000_000,
  parameter int BAUD_RATE    = 31250,
  parameter int MIDI_CHANNEL = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         noteOnStrb_i,
  input  logic                         noteOffStrb_i,
  input  logic [MIDI_PAYLOAD_BITS-1:0] note_i,
  input  logic [MIDI_PAYLOAD_BITS-1:0] velocity_i,
  output logic                         ready_o,
  output logic                         txData_o,
  output logic                         msgDone_o
);

  localparam int DIV = CLK_FREQ / BAUD_RATE;

  msgState_t                    msgState;
  logic [MIDI_PAYLOAD_BITS-1:0] noteReg;
  logic [MIDI_PAYLOAD_BITS-1:0] velocityReg;
  logic                         readyReg;
  logic                         msgDoneReg;

  logic                         byteDone;
  logic                         byteBusy;
  logic                         byteLoad;
  logic [MIDI_PAYLOAD_BITS-1:0] byteData;
  logic                         lastByteDone;
  logic                         accept;
  logic                         unusedBits;

  // Bit 7 of the data bytes is always 0 on the wire; busy is implied by msgState.
  assign unusedBits = ^{note_i[7], velocity_i[7], byteBusy};

  assign ready_o   = readyReg;
  assign msgDone_o = msgDoneReg;

  // Accept decision and byte mux feeding the serializer.
  always_comb begin
    lastByteDone = (msgState == M_BYTE2) && byteDone;
    accept       = (readyReg || lastByteDone) && (noteOnStrb_i || noteOffStrb_i);
    byteLoad     = 1'b0;
    byteData     = '0;
    if (accept) begin
      byteLoad = 1'b1;
      byteData = statusByte(noteOffStrb_i, 4'(MIDI_CHANNEL));
    end else if (byteDone && msgState == M_BYTE0) begin
      byteLoad = 1'b1;
      byteData = noteReg;
    end else if (byteDone && msgState == M_BYTE1) begin
      byteLoad = 1'b1;
      byteData = velocityReg;
    end
  end

  // Message FSM with registered ready/done and payload capture on accept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      msgState    <= M_IDLE;
      noteReg     <= '0;
      velocityReg <= '0;
      readyReg    <= 1'b1;
      msgDoneReg  <= 1'b0;
    end else begin
      msgDoneReg <= lastByteDone;
      if (accept) begin
        msgState    <= M_BYTE0;
        readyReg    <= 1'b0;
        noteReg     <= {1'b0, note_i[6:0]};
        velocityReg <= {1'b0, velocity_i[6:0]};
      end else if (byteDone) begin
        unique case (msgState)
          M_BYTE0: msgState <= M_BYTE1;
          M_BYTE1: msgState <= M_BYTE2;
          M_BYTE2: begin
            msgState <= M_IDLE;
            readyReg <= 1'b1;
          end
          default: msgState <= M_IDLE;
        endcase
      end
    end
  end

  uart_tx_byte #(
    .DIV(DIV)
  ) byteTx (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .data_i  (byteData),
    .load_i  (byteLoad),
    .busy_o  (byteBusy),
    .done_o  (byteDone),
    .txData_o(txData_o)
  );

endmodule

// File: tb/tb_midi_tx.sv
// Directed bench for midi_tx: two instances (channel 0 and 5) share the stimulus,
// and every cycle of each serial line is compared against the expected 30-bit message.
module tb_midi_tx;

  localparam int DIV = 8;
  localparam int MSG_CYCLES = 30 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       on = 1'b0;
  logic       off = 1'b0;
  logic [7:0] note = 8'h00;
  logic [7:0] vel = 8'h00;

  logic ready0, tx0, done0;
  logic ready5, tx5, done5;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  midi_tx #(.CLK_FREQ(250_000), .BAUD_RATE(31250), .MIDI_CHANNEL(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .noteOnStrb_i(on), .noteOffStrb_i(off),
    .note_i(note), .velocity_i(vel), .ready_o(ready0), .txData_o(tx0), .msgDone_o(done0)
  );

  midi_tx #(.CLK_FREQ(250_000), .BAUD_RATE(31250), .MIDI_CHANNEL(5)) dut5 (
    .clk_i(clk), .rst_i(rst), .noteOnStrb_i(on), .noteOffStrb_i(off),
    .note_i(note), .velocity_i(vel), .ready_o(ready5), .txData_o(tx5), .msgDone_o(done5)
  );

  // One-cycle request; returns half a cycle after the accepting edge.
  task automatic strobe(input logic o, input logic f, input logic [7:0] n, input logic [7:0] v);
    @(negedge clk);
    on = o; off = f; note = n; vel = v;
    @(negedge clk);
    on = 1'b0; off = 1'b0;
    note = 8'hEE; vel = 8'hDD;  // payload must already be captured
  endtask

  // Follows one message cycle by cycle, then checks the msgDone edge.
  task automatic observe(input string name, input logic [7:0] s0, input logic [7:0] s5,
                         input logic [7:0] b1, input logic [7:0] b2, input int dropAt,
                         input bit chain, input logic [7:0] cn, input logic [7:0] cv);
    logic [29:0] exp0, exp5;
    logic [7:0]  got0 [3];
    logic [7:0]  got5 [3];
    logic [7:0]  want0 [3];
    logic [7:0]  want5 [3];
    int bad0, bad5, badReady, badDone;
    exp0 = {1'b1, b2, 1'b0, 1'b1, b1, 1'b0, 1'b1, s0, 1'b0};
    exp5 = {1'b1, b2, 1'b0, 1'b1, b1, 1'b0, 1'b1, s5, 1'b0};
    want0[0] = s0; want0[1] = b1; want0[2] = b2;
    want5[0] = s5; want5[1] = b1; want5[2] = b2;
    for (int j = 0; j < 3; j++) begin
      got0[j] = 8'h00; got5[j] = 8'h00;
    end
    bad0 = 0; bad5 = 0; badReady = 0; badDone = 0;
    for (int t = 0; t < MSG_CYCLES; t++) begin
      int k, ph, pos;
      k = t / DIV; ph = t % DIV; pos = k % 10;
      if (tx0 !== exp0[k]) bad0++;
      if (tx5 !== exp5[k]) bad5++;
      if (ph == DIV / 2 && pos >= 1 && pos <= 8) begin
        got0[k / 10][pos - 1] = tx0;
        got5[k / 10][pos - 1] = tx5;
      end
      if (ready0 !== 1'b0 || ready5 !== 1'b0) badReady++;
      if (t > 0 && (done0 !== 1'b0 || done5 !== 1'b0)) badDone++;
      if (t == dropAt) begin
        on = 1'b1; note = 8'h11; vel = 8'h22;
      end
      if (chain && t == MSG_CYCLES - 1) begin
        on = 1'b1; note = cn; vel = cv;
      end
      @(negedge clk);
      on = 1'b0; off = 1'b0;
    end
    checks++;
    if (bad0 != 0) begin
      fails++; $display("FAIL %s line0 timing: %0d bad cycles, required 0", name, bad0);
    end
    checks++;
    if (bad5 != 0) begin
      fails++; $display("FAIL %s line5 timing: %0d bad cycles, required 0", name, bad5);
    end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (got0[j] !== want0[j] || got5[j] !== want5[j]) begin
        fails++;
        $display("FAIL %s byte%0d: got %h/%h, required %h/%h", name, j, got0[j], got5[j],
                 want0[j], want5[j]);
      end
    end
    checks++;
    if (badReady != 0) begin
      fails++; $display("FAIL %s ready low: %0d cycles high, required 0", name, badReady);
    end
    checks++;
    if (badDone != 0) begin
      fails++; $display("FAIL %s early msgDone: %0d cycles, required 0", name, badDone);
    end
    checks++;
    if (done0 !== 1'b1 || done5 !== 1'b1) begin
      fails++; $display("FAIL %s msgDone: got %b/%b, required 1/1", name, done0, done5);
    end
    checks++;
    if (chain) begin
      if (tx0 !== 1'b0 || ready0 !== 1'b0 || tx5 !== 1'b0 || ready5 !== 1'b0) begin
        fails++;
        $display("FAIL %s chained start: tx %b/%b ready %b/%b, required tx 0 ready 0",
                 name, tx0, tx5, ready0, ready5);
      end
    end else begin
      if (tx0 !== 1'b1 || ready0 !== 1'b1 || tx5 !== 1'b1 || ready5 !== 1'b1) begin
        fails++;
        $display("FAIL %s end idle: tx %b/%b ready %b/%b, required tx 1 ready 1",
                 name, tx0, tx5, ready0, ready5);
      end
    end
    $display("msg %s: ch0 %h %h %h ch5 %h %h %h", name, got0[0], got0[1], got0[2],
             got5[0], got5[1], got5[2]);
  endtask

  // After a message: msgDone drops and the line stays idle (nothing extra sent).
  task automatic endIdle(input string name);
    int bad;
    bad = 0;
    for (int t = 0; t < 3 * DIV; t++) begin
      @(negedge clk);
      if (done0 !== 1'b0 || done5 !== 1'b0 || tx0 !== 1'b1 || tx5 !== 1'b1 ||
          ready0 !== 1'b1 || ready5 !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      fails++; $display("FAIL %s idle after: %0d bad cycles, required 0", name, bad);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (tx0 !== 1'b1 || ready0 !== 1'b1 || done0 !== 1'b0 ||
        tx5 !== 1'b1 || ready5 !== 1'b1 || done5 !== 1'b0) begin
      fails++;
      $display("FAIL reset: tx %b/%b ready %b/%b done %b/%b, required tx 1 ready 1 done 0",
               tx0, tx5, ready0, ready5, done0, done5);
    end
    rst = 1'b0;
    @(negedge clk);
    $display("reset released");
  endtask

  task automatic test_note_on();
    strobe(1'b1, 1'b0, 8'h3C, 8'h64);
    observe("noteOn", 8'h90, 8'h95, 8'h3C, 8'h64, -1, 1'b0, 8'h00, 8'h00);
    endIdle("noteOn");
  endtask

  task automatic test_note_off();
    strobe(1'b0, 1'b1, 8'hBC, 8'hFF);
    observe("noteOff", 8'h80, 8'h85, 8'h3C, 8'h7F, -1, 1'b0, 8'h00, 8'h00);
    endIdle("noteOff");
  endtask

  task automatic test_simultaneous();
    strobe(1'b1, 1'b1, 8'h45, 8'h10);
    observe("both", 8'h80, 8'h85, 8'h45, 8'h10, -1, 1'b0, 8'h00, 8'h00);
    endIdle("both");
  endtask

  task automatic test_busy_drop();
    strobe(1'b1, 1'b0, 8'h30, 8'h40);
    observe("busyDrop", 8'h90, 8'h95, 8'h30, 8'h40, 100, 1'b0, 8'h00, 8'h00);
    endIdle("busyDrop");
  endtask

  task automatic test_back_to_back();
    strobe(1'b1, 1'b0, 8'h3C, 8'h64);
    observe("chainA", 8'h90, 8'h95, 8'h3C, 8'h64, -1, 1'b1, 8'h50, 8'h20);
    observe("chainB", 8'h90, 8'h95, 8'h50, 8'h20, -1, 1'b0, 8'h00, 8'h00);
    endIdle("chainB");
  endtask

  task automatic test_reset_mid_frame();
    strobe(1'b1, 1'b0, 8'h34, 8'h64);
    // Land in the middle of data bit 3 of byte 1 (message bit 14); 0x34 has bit3 = 0.
    repeat (14 * DIV + 2) @(negedge clk);
    checks++;
    if (tx0 !== 1'b0) begin
      fails++; $display("FAIL midFrame bit3: got %b, required 0", tx0);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (tx0 !== 1'b1 || ready0 !== 1'b1 || done0 !== 1'b0 ||
        tx5 !== 1'b1 || ready5 !== 1'b1 || done5 !== 1'b0) begin
      fails++;
      $display("FAIL midFrame reset: tx %b/%b ready %b/%b done %b/%b, required 1 1 0",
               tx0, tx5, ready0, ready5, done0, done5);
    end
    rst = 1'b0;
    $display("reset applied mid-frame");
    strobe(1'b1, 1'b0, 8'h40, 8'h7F);
    observe("afterReset", 8'h90, 8'h95, 8'h40, 8'h7F, -1, 1'b0, 8'h00, 8'h00);
    endIdle("afterReset");
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_note_off();
    test_simultaneous();
    test_busy_drop();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
